seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 187 ++++++++++++++++++
 tb/tb_seq_alu.sv | 127 ++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle integer ops plus WIDTH-cycle shift/add multiply
// and restoring divide, with a valid/ready handshake on both sides.
module seq_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int unsigned LOG2W = $clog2(WIDTH);
  localparam int unsigned CNT_W = LOG2W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,  OP_SUB  = 5'd1,  OP_SLL    = 5'd2,  OP_XOR   = 5'd3,
    OP_OR     = 5'd4,  OP_AND  = 5'd5,  OP_SRL    = 5'd6,  OP_SRA   = 5'd7,
    OP_SLT    = 5'd8,  OP_SLTU = 5'd9,  OP_MUL    = 5'd16, OP_MULH  = 5'd17,
    OP_MULHSU = 5'd18, OP_MULHU = 5'd19, OP_DIV   = 5'd20, OP_DIVU  = 5'd21,
    OP_REM    = 5'd22, OP_REMU = 5'd23
  } op_e;

  state_e             state_q, state_d;
  logic [4:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;

  logic               accept;
  logic [LOG2W-1:0]   shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               is_seq, is_div, div_sgn, b_zero, div_ovf, special;
  logic [WIDTH-1:0]   special_res;
  logic               a_neg, b_neg, neg_init;
  logic [WIDTH-1:0]   a_mag, b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nx;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_df, div_rem;
  logic [2*WIDTH-1:0] div_nx, step_nx, full_s;
  logic [WIDTH-1:0]   lo_s, hi_s, fin;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign accept    = in_valid & in_ready;
  assign shamt     = b[LOG2W-1:0];

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_SLL:  alu_res = a << shamt;
      OP_XOR:  alu_res = a ^ b;
      OP_OR:   alu_res = a | b;
      OP_AND:  alu_res = a & b;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: alu_res = '0;
    endcase
  end

  // Iterative ops work on magnitudes; neg records whether the final value
  // (product, quotient, or remainder for REM) must be negated.
  always_comb begin
    is_seq   = (op[4:3] == 2'b10);
    is_div   = (op[4:2] == 3'b101);
    div_sgn  = is_div & ~op[0];
    b_zero   = (b == '0);
    div_ovf  = div_sgn & (a == MOST_NEG) & (b == '1);
    special  = is_div & (b_zero | div_ovf);
    if (b_zero) special_res = op[1] ? a : '1;
    else        special_res = op[1] ? '0 : a;
    a_neg    = (div_sgn | (op == OP_MULH) | (op == OP_MULHSU)) & a[WIDTH-1];
    b_neg    = (div_sgn | (op == OP_MULH)) & b[WIDTH-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    neg_init = (is_div & op[1]) ? a_neg : (a_neg ^ b_neg);
  end

  always_comb begin
    mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    mul_nx  = {mul_sum, prod_q[WIDTH-1:1]};
    div_sh  = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    div_ge  = (div_sh >= {1'b0, mcand_q});
    div_df  = div_sh[WIDTH-1:0] - mcand_q;
    div_rem = div_ge ? div_df : div_sh[WIDTH-1:0];
    div_nx  = {div_rem, prod_q[WIDTH-2:0], div_ge};
    step_nx = op_q[2] ? div_nx : mul_nx;
    full_s  = neg_q ? -step_nx : step_nx;
    lo_s    = neg_q ? -step_nx[WIDTH-1:0] : step_nx[WIDTH-1:0];
    hi_s    = neg_q ? -step_nx[2*WIDTH-1:WIDTH] : step_nx[2*WIDTH-1:WIDTH];
    case (op_q[2:0])
      3'd0:       fin = full_s[WIDTH-1:0];
      3'd1, 3'd2,
      3'd3:       fin = full_s[2*WIDTH-1:WIDTH];
      3'd4, 3'd5: fin = lo_s;
      default:    fin = hi_s;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = op;
          neg_d = neg_init;
          if (special) begin
            result_d = special_res;
            state_d  = DONE;
          end else if (is_seq) begin
            cnt_d   = '0;
            prod_d  = {{WIDTH{1'b0}}, (op[2] ? a_mag : b_mag)};
            mcand_d = op[2] ? b_mag : a_mag;
            state_d = CALC;
          end else begin
            result_d = alu_res;
            state_d  = DONE;
          end
        end
      end
      CALC: begin
        prod_d = step_nx;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          result_d = fin;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=32.
module tb_seq_alu;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready, zero;
  logic [W-1:0] a, b, result;
  logic [4:0]   op;
  int           tests = 0;
  int           fails = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge after the handshake.
  task automatic run_op(input string tag, input logic [4:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] exp, input int lat,
                        input int hold);
    int cyc;
    chk({tag, " in_ready"}, W'(in_ready), W'(1));
    in_valid = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    in_valid = 1'b0; op = ~o; a = ~x; b = ~y;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, W'(cyc), W'(lat));
    chk({tag, " result"}, result, exp);
    chk({tag, " zero"}, W'(zero), W'(exp == '0));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; op = 5'd0; a = W'(i + 1); b = W'(i + 9);
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, " hold out_valid"}, W'(out_valid), W'(1));
      chk({tag, " hold result"}, result, exp);
      chk({tag, " hold zero"}, W'(zero), W'(exp == '0));
      chk({tag, " hold in_ready"}, W'(in_ready), W'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " out_valid drop"}, W'(out_valid), W'(0));
    chk({tag, " in_ready back"}, W'(in_ready), W'(1));
  endtask

  initial begin
    int  seen;
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0; op = 5'd0; a = 1; b = 1;
    repeat (3) @(negedge clk);
    chk("rst out_valid", W'(out_valid), W'(0));
    chk("rst result", result, '0);
    chk("rst zero", W'(zero), W'(1));
    chk("rst in_ready", W'(in_ready), W'(1));
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post rst out_valid", W'(out_valid), W'(0));

    run_op("add wrap", 5'd0,  32'hFFFF_FFFF, 32'h1,         32'h0,         1, 0);
    run_op("sub",      5'd1,  32'h0,         32'h1,         32'hFFFF_FFFF, 1, 0);
    run_op("sll",      5'd2,  32'h1,         32'h21,        32'h2,         1, 0);
    run_op("xor",      5'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1, 0);
    run_op("or",       5'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1, 0);
    run_op("and",      5'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1, 0);
    run_op("srl",      5'd6,  32'h8000_0000, 32'h1F,        32'h1,         1, 0);
    run_op("sra",      5'd7,  32'h8000_0000, 32'h24,        32'hF800_0000, 1, 0);
    run_op("slt",      5'd8,  32'hFFFF_FFFF, 32'h0,         32'h1,         1, 0);
    run_op("sltu",     5'd9,  32'hFFFF_FFFF, 32'h0,         32'h0,         1, 0);
    run_op("undef",    5'd10, 32'h5,         32'h3,         32'h0,         1, 0);

    run_op("mul",      5'd16, 32'h1234_5678, 32'h10,        32'h2345_6780, 33, 0);
    run_op("mulh",     5'd17, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0);
    run_op("mulhsu",   5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0);
    run_op("mulhu",    5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
    run_op("div neg",  5'd20, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 33, 0);
    run_op("rem neg",  5'd22, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 33, 0);
    run_op("divu",     5'd21, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 33, 0);
    run_op("remu",     5'd23, 32'd100,       32'd7,         32'd2,         33, 0);
    run_op("divu by0", 5'd21, 32'h1234,      32'h0,         32'hFFFF_FFFF, 1, 0);
    run_op("rem by0",  5'd22, 32'h8765_4321, 32'h0,         32'h8765_4321, 1, 0);
    run_op("div ovf",  5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("rem ovf",  5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1, 0);

    run_op("backpress", 5'd0, 32'd3, 32'd4, 32'd7, 1, 5);

    // Abort a DIVU with reset during its 10th CALC cycle.
    chk("abort in_ready", W'(in_ready), W'(1));
    in_valid = 1'b1; op = 5'd21; a = 32'd1000; b = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("abort rst out_valid", W'(out_valid), W'(0));
    chk("abort rst in_ready", W'(in_ready), W'(1));
    chk("abort rst result", result, '0);
    chk("abort rst zero", W'(zero), W'(1));
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("abort first in_ready", W'(in_ready), W'(1));
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) seen = 1;
      @(negedge clk);
    end
    chk("abort no out_valid", W'(seen), W'(0));
    run_op("add after abort", 5'd0, 32'd2, 32'd3, 32'd5, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
